// File: rtl/lbfgs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lbfgs_pkg
//  Description : Shared types and constants for the L-BFGS search-direction
//                unit (SDU) history controller: sequencer state encoding,
//                SDU operation codes and the default history depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package lbfgs_pkg;

  // History depth m. Not a power of two, so a $clog2-wide count can hold m.
  localparam int DEFAULT_NUM_LOOP = 10;

  // SDU operation select codes
  localparam logic [1:0] SDU_OP_AXPY   = 2'b00;
  localparam logic [1:0] SDU_OP_SEARCH = 2'b01;
  localparam logic [1:0] SDU_OP_DOT    = 2'b10;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } hist_state_e;

endpackage
`default_nettype wire

// File: rtl/ring_index_map.sv
`default_nettype none
// ============================================================================
//  Module      : ring_index_map
//  Description : Combinational mapping of a two-loop stream index j onto a
//                circular history slot.
//                  j <  m : (newest - j)       mod NUM_LOOP  (first loop)
//                  j >= m : (oldest + (j - m)) mod NUM_LOOP  (second loop)
//  Ports       : j      - stream index, 0..2m-1
//                m      - history count snapshot
//                newest - slot of the newest entry (snapshot)
//                oldest - slot of the oldest entry (snapshot)
//                slot   - resulting history slot address
//  Revision    : 1.0 - initial release
// ============================================================================
module ring_index_map
  import lbfgs_pkg::*;
#(
  parameter int NUM_LOOP = DEFAULT_NUM_LOOP,
  parameter int AW       = $clog2(NUM_LOOP),
  parameter int CW       = $clog2(NUM_LOOP),
  parameter int JW       = $clog2(2 * NUM_LOOP)
) (
  input  logic [JW-1:0] j,
  input  logic [CW-1:0] m,
  input  logic [AW-1:0] newest,
  input  logic [AW-1:0] oldest,
  output logic [AW-1:0] slot
);

  // Wide enough that newest+N and oldest+(j-m) never wrap.
  localparam int            IW  = JW + AW + CW + 1;
  localparam logic [IW-1:0] N_W = IW'(NUM_LOOP);

  logic [IW-1:0] j_w, m_w, new_w, old_w, sum_w, res_w;

  // Wraparound by compare/add of NUM_LOOP: N is not a power of two, so a
  // bit mask would give wrong slots.
  always_comb begin
    j_w   = IW'(j);
    m_w   = IW'(m);
    new_w = IW'(newest);
    old_w = IW'(oldest);
    sum_w = '0;
    res_w = '0;
    if (j_w < m_w) begin
      if (new_w >= j_w) res_w = new_w - j_w;
      else              res_w = new_w + N_W - j_w;
    end else begin
      sum_w = old_w + (j_w - m_w);
      res_w = (sum_w >= N_W) ? (sum_w - N_W) : sum_w;
    end
  end

  assign slot = AW'(res_w);

endmodule
`default_nettype wire

// File: rtl/sdu_history_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sdu_history_ctrl
//  Description : Sequencer and circular (s, y, rho) history address manager
//                for the L-BFGS SDU. Tracks write slot and valid count,
//                launches the two-loop recursion, and turns the SDU's per-
//                stream read pulses into history slot addresses (first loop
//                newest->oldest, second loop oldest->newest).
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                hist_clear          - empty the history (priority over all)
//                hist_push / wr_addr - history write strobe / target slot
//                push_err            - pulse: push rejected while running
//                start / loop_end    - launch request / SDU completion pulse
//                s/y/rho_rd_en       - SDU consumed current element
//                s/y/rho_addr        - slot presented to the SDU per stream
//                sdu_op, busy, done  - SDU op select, running flag, end pulse
//                num_loop_current    - history count snapshot for the SDU
//                hist_count          - valid entries (0..NUM_LOOP)
//  Revision    : 1.0 - initial release
// ============================================================================
module sdu_history_ctrl
  import lbfgs_pkg::*;
#(
  parameter int NUM_LOOP = DEFAULT_NUM_LOOP,
  parameter int AW       = $clog2(NUM_LOOP),
  parameter int CW       = $clog2(NUM_LOOP)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hist_clear,
  input  logic          hist_push,
  output logic [AW-1:0] wr_addr,
  output logic          push_err,
  input  logic          start,
  input  logic          loop_end,
  input  logic          s_rd_en,
  input  logic          y_rd_en,
  input  logic          rho_rd_en,
  output logic [AW-1:0] s_addr,
  output logic [AW-1:0] y_addr,
  output logic [AW-1:0] rho_addr,
  output logic [1:0]    sdu_op,
  output logic [CW-1:0] num_loop_current,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] hist_count
);

  localparam int JW = $clog2(2 * NUM_LOOP);
  localparam int XW = AW + CW + 1;

  hist_state_e   state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] m_q, m_d;
  logic [AW-1:0] newest_q, newest_d, oldest_q, oldest_d;
  logic [JW-1:0] js_q, js_d, jy_q, jy_d, jr_q, jr_d;
  logic          push_err_q, push_err_d;

  logic          push_ok;
  logic [AW-1:0] newest_c, oldest_c;
  logic [JW-1:0] j_max;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    m_d        = m_q;
    newest_d   = newest_q;
    oldest_d   = oldest_q;
    js_d       = js_q;
    jy_d       = jy_q;
    jr_d       = jr_q;
    push_err_d = 1'b0;
    j_max      = JW'({m_q, 1'b0}) - JW'(1);

    // Ring update first so a start in the same cycle sees the new entry.
    push_ok = hist_push && (state_q != ST_RUN);
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == AW'(NUM_LOOP - 1)) ? '0 : wr_ptr_q + AW'(1);
      if (count_q != CW'(NUM_LOOP)) count_d = count_q + CW'(1);
    end

    newest_c = (wr_ptr_d == '0) ? AW'(NUM_LOOP - 1) : wr_ptr_d - AW'(1);
    if (XW'(wr_ptr_d) >= XW'(count_d))
      oldest_c = AW'(XW'(wr_ptr_d) - XW'(count_d));
    else
      oldest_c = AW'(XW'(wr_ptr_d) + XW'(NUM_LOOP) - XW'(count_d));

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (count_d != '0) begin
            state_d  = ST_RUN;
            m_d      = count_d;
            newest_d = newest_c;
            oldest_d = oldest_c;
            js_d     = '0;
            jy_d     = '0;
            jr_d     = '0;
          end else begin
            // Empty history: nothing to recurse over, finish immediately.
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        push_err_d = hist_push;
        if (s_rd_en   && (js_q != j_max)) js_d = js_q + JW'(1);
        if (y_rd_en   && (jy_q != j_max)) jy_d = jy_q + JW'(1);
        if (rho_rd_en && (jr_q != j_max)) jr_d = jr_q + JW'(1);
        if (loop_end) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (hist_clear) begin
      state_d    = ST_IDLE;
      wr_ptr_d   = '0;
      count_d    = '0;
      push_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      m_q        <= '0;
      newest_q   <= '0;
      oldest_q   <= '0;
      js_q       <= '0;
      jy_q       <= '0;
      jr_q       <= '0;
      push_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      m_q        <= m_d;
      newest_q   <= newest_d;
      oldest_q   <= oldest_d;
      js_q       <= js_d;
      jy_q       <= jy_d;
      jr_q       <= jr_d;
      push_err_q <= push_err_d;
    end
  end

  ring_index_map #(.NUM_LOOP(NUM_LOOP), .AW(AW), .CW(CW), .JW(JW)) u_s_map (
    .j(js_q), .m(m_q), .newest(newest_q), .oldest(oldest_q), .slot(s_addr)
  );
  ring_index_map #(.NUM_LOOP(NUM_LOOP), .AW(AW), .CW(CW), .JW(JW)) u_y_map (
    .j(jy_q), .m(m_q), .newest(newest_q), .oldest(oldest_q), .slot(y_addr)
  );
  ring_index_map #(.NUM_LOOP(NUM_LOOP), .AW(AW), .CW(CW), .JW(JW)) u_rho_map (
    .j(jr_q), .m(m_q), .newest(newest_q), .oldest(oldest_q), .slot(rho_addr)
  );

  assign wr_addr          = wr_ptr_q;
  assign push_err         = push_err_q;
  assign hist_count       = count_q;
  assign num_loop_current = m_q;
  assign busy             = (state_q == ST_RUN);
  assign done             = (state_q == ST_DONE);
  assign sdu_op           = (state_q == ST_RUN) ? SDU_OP_SEARCH : SDU_OP_AXPY;

endmodule
`default_nettype wire

// File: tb/tb_sdu_history_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdu_history_ctrl
//  Description : Scoreboard bench for sdu_history_ctrl. The history is
//                modelled as a list of slots in age order; stream addresses
//                are read straight from that list (reversed, then forward).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sdu_history_ctrl;

  localparam int N  = 10;
  localparam int AW = 4;
  localparam int CW = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_DONE = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          hist_clear, hist_push, start, loop_end;
  logic          s_rd_en, y_rd_en, rho_rd_en;
  logic [AW-1:0] wr_addr, s_addr, y_addr, rho_addr;
  logic          push_err, busy, done;
  logic [1:0]    sdu_op;
  logic [CW-1:0] num_loop_current, hist_count;

  sdu_history_ctrl #(.NUM_LOOP(N), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .hist_clear(hist_clear), .hist_push(hist_push),
    .wr_addr(wr_addr), .push_err(push_err), .start(start), .loop_end(loop_end),
    .s_rd_en(s_rd_en), .y_rd_en(y_rd_en), .rho_rd_en(rho_rd_en),
    .s_addr(s_addr), .y_addr(y_addr), .rho_addr(rho_addr), .sdu_op(sdu_op),
    .num_loop_current(num_loop_current), .busy(busy), .done(done),
    .hist_count(hist_count)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  // Scoreboard queues
  int q_s[$], q_y[$], q_r[$];
  int q_done[$], q_perr[$], q_bcyc[$], q_bm[$];
  int q_pwr[$], q_pcnt[$], q_pbusy[$], q_pfull[$];
  logic chk_s = 1'b0, chk_y = 1'b0, chk_r = 1'b0, probe = 1'b0;

  // Reference model: slots in age order (oldest first)
  int hist[$];
  int snap[$];
  int wr_m = 0;
  int ms   = S_IDLE;
  int m_m  = 0;
  int jx[3];

  function automatic int map_addr(int j);
    return (j < m_m) ? snap[m_m-1-j] : snap[j-m_m];
  endfunction

  // ---------------- monitor ----------------
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (chk_s) begin
        chk("s_expected", int'(q_s.size() != 0), 1);
        if (q_s.size() != 0) chk("s_addr", int'(s_addr), q_s.pop_front());
      end
      if (chk_y) begin
        chk("y_expected", int'(q_y.size() != 0), 1);
        if (q_y.size() != 0) chk("y_addr", int'(y_addr), q_y.pop_front());
      end
      if (chk_r) begin
        chk("rho_expected", int'(q_r.size() != 0), 1);
        if (q_r.size() != 0) chk("rho_addr", int'(rho_addr), q_r.pop_front());
      end
      if (busy && !prev_busy) begin
        chk("busy_expected", int'(q_bcyc.size() != 0), 1);
        if (q_bcyc.size() != 0) begin
          chk("busy_cycle", cyc_cnt, q_bcyc.pop_front());
          chk("num_loop_current", int'(num_loop_current), q_bm.pop_front());
          chk("sdu_op_run", int'(sdu_op), 1);
        end
      end
      if (done) begin
        chk("done_expected", int'(q_done.size() != 0), 1);
        if (q_done.size() != 0) begin
          chk("done_cycle", cyc_cnt, q_done.pop_front());
          chk("sdu_op_done", int'(sdu_op), 0);
          chk("busy_in_done", int'(busy), 0);
        end
      end
      if (push_err) begin
        chk("push_err_expected", int'(q_perr.size() != 0), 1);
        if (q_perr.size() != 0) chk("push_err_cycle", cyc_cnt, q_perr.pop_front());
      end
      if (probe && q_pwr.size() != 0) begin
        chk("wr_addr", int'(wr_addr), q_pwr.pop_front());
        chk("hist_count", int'(hist_count), q_pcnt.pop_front());
        chk("busy", int'(busy), q_pbusy.pop_front());
        if (q_pfull.pop_front() != 0) begin
          chk("rst_done", int'(done), 0);
          chk("rst_sdu_op", int'(sdu_op), 0);
          chk("rst_push_err", int'(push_err), 0);
          chk("rst_num_loop_current", int'(num_loop_current), 0);
          chk("rst_s_addr", int'(s_addr), 0);
          chk("rst_y_addr", int'(y_addr), 0);
          chk("rst_rho_addr", int'(rho_addr), 0);
        end
      end
      prev_busy <= busy;
    end
  end

  // ---------------- driver + model ----------------
  task automatic step(input bit push, input bit st, input bit le,
                      input bit [2:0] rd, input bit clr);
    int c;
    c = cyc_cnt;
    hist_push = push; start = st; loop_end = le; hist_clear = clr;
    s_rd_en = rd[0]; y_rd_en = rd[1]; rho_rd_en = rd[2];
    if (ms == S_RUN) begin
      if (rd[0]) begin q_s.push_back(map_addr(jx[0])); chk_s = 1'b1; if (jx[0] < 2*m_m-1) jx[0]++; end
      if (rd[1]) begin q_y.push_back(map_addr(jx[1])); chk_y = 1'b1; if (jx[1] < 2*m_m-1) jx[1]++; end
      if (rd[2]) begin q_r.push_back(map_addr(jx[2])); chk_r = 1'b1; if (jx[2] < 2*m_m-1) jx[2]++; end
    end
    if (clr) begin
      hist.delete();
      wr_m = 0;
      ms   = S_IDLE;
    end else begin
      if (push) begin
        if (ms == S_RUN) q_perr.push_back(c + 1);
        else begin
          hist.push_back(wr_m);
          if (hist.size() > N) void'(hist.pop_front());
          wr_m = (wr_m + 1) % N;
        end
      end
      case (ms)
        S_IDLE: if (st) begin
          if (hist.size() > 0) begin
            ms = S_RUN; m_m = hist.size(); snap = hist;
            jx[0] = 0; jx[1] = 0; jx[2] = 0;
            q_bcyc.push_back(c + 1); q_bm.push_back(m_m);
          end else begin
            ms = S_DONE; q_done.push_back(c + 1);
          end
        end
        S_RUN: if (le) begin ms = S_DONE; q_done.push_back(c + 1); end
        default: ms = S_IDLE;
      endcase
    end
    @(posedge clk);
    #1;
    hist_push = 1'b0; start = 1'b0; loop_end = 1'b0; hist_clear = 1'b0;
    s_rd_en = 1'b0; y_rd_en = 1'b0; rho_rd_en = 1'b0;
    chk_s = 1'b0; chk_y = 1'b0; chk_r = 1'b0; probe = 1'b0;
  endtask

  task automatic pr(input bit full);
    probe = 1'b1;
    q_pwr.push_back(wr_m);
    q_pcnt.push_back(hist.size());
    q_pbusy.push_back(int'(ms == S_RUN));
    q_pfull.push_back(int'(full));
    step(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    hist_clear = 1'b0; hist_push = 1'b0; start = 1'b0; loop_end = 1'b0;
    s_rd_en = 1'b0; y_rd_en = 1'b0; rho_rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    pr(1'b1);

    // Three entries, s stream over both loops
    repeat (3) step(1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    step(1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
    repeat (6) step(1'b0, 1'b0, 1'b0, 3'b001, 1'b0);
    step(1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
    step(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    pr(1'b0);

    // Ring wrap: twelve pushes after a clear, full y sweep
    step(1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    repeat (12) step(1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    pr(1'b0);
    step(1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
    repeat (20) step(1'b0, 1'b0, 1'b0, 3'b010, 1'b0);
    step(1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
    step(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);

    // Empty-history start
    step(1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    step(1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    pr(1'b0);

    // Push rejected in RUN, then clear mid-run
    repeat (4) step(1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    step(1'b0, 1'b1, 1'b0, 3'b000, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 3'b111, 1'b0);
    step(1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    pr(1'b0);
    step(1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
    pr(1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);

    // Push and start together, rho saturation
    repeat (4) step(1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
    step(1'b1, 1'b1, 1'b0, 3'b000, 1'b0);
    repeat (12) step(1'b0, 1'b0, 1'b0, 3'b100, 1'b0);
    step(1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
    step(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    pr(1'b0);

    // Randomized runs
    for (int it = 0; it < 30; it++) begin
      int np, nc;
      if ($urandom_range(0, 4) == 0) step(1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
      np = $urandom_range(0, 13);
      for (int i = 0; i < np; i++) step(1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
      step($urandom_range(0, 1) == 1, 1'b1, 1'b0, 3'b000, 1'b0);
      nc = $urandom_range(0, 25);
      for (int i = 0; i < nc; i++)
        step($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, 1'b0,
             3'($urandom_range(0, 7)), 1'b0);
      if ($urandom_range(0, 5) == 0) step(1'b0, 1'b0, 1'b0, 3'b000, 1'b1);
      else                           step(1'b0, 1'b0, 1'b1, 3'b000, 1'b0);
      step(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
      pr(1'b0);
    end

    repeat (4) step(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    chk("leftover_done", q_done.size(), 0);
    chk("leftover_busy", q_bcyc.size(), 0);
    chk("leftover_push_err", q_perr.size(), 0);
    chk("leftover_s", q_s.size(), 0);
    chk("leftover_y", q_y.size(), 0);
    chk("leftover_rho", q_r.size(), 0);
    chk("leftover_probe", q_pwr.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
